// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game-flow controller and its environment
// (keyboard, transition animator, collision logic, sprite/colour mappers).
interface game_flow_ctrl_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int KEY_SLOTS   = 4
);
   logic                     FrameTick;
   logic [8*KEY_SLOTS-1:0]   Keycode;
   logic                     StartTransitionDone;
   logic [NUM_PLAYERS-1:0]   PlayerCrash;

   logic                     StartGame;
   logic                     StartTransition;
   logic                     DrawGame;
   logic                     Paused;
   logic                     DrawWinner;
   logic                     EndGame;
   logic [NUM_PLAYERS-1:0]   Winner;
   logic                     Draw;

   modport master (
      output FrameTick, Keycode, StartTransitionDone, PlayerCrash,
      input  StartGame, StartTransition, DrawGame, Paused, DrawWinner,
             EndGame, Winner, Draw
   );

   modport slave (
      input  FrameTick, Keycode, StartTransitionDone, PlayerCrash,
      output StartGame, StartTransition, DrawGame, Paused, DrawWinner,
             EndGame, Winner, Draw
   );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: title, transition, gameplay, pause, results, end screens.
// Driven by edge-detected keycodes, crash flags and a per-frame tick enable.
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_START     | title screen, waiting for Enter
// ST_TRANS     | title-to-game transition animation running
// ST_GAME      | gameplay
// ST_PAUSE     | gameplay frozen, P resumes
// ST_RESULTS   | winner screen held for RESULTS_FRAMES frame ticks
// ST_END       | end screen, Enter returns to title
module game_flow_ctrl #(
   parameter int         NUM_PLAYERS    = 2,
   parameter int         KEY_SLOTS      = 4,
   parameter logic [7:0] START_KEY      = 8'h28,
   parameter logic [7:0] QUIT_KEY       = 8'h35,
   parameter logic [7:0] PAUSE_KEY      = 8'h13,
   parameter int         RESULTS_FRAMES = 300,
   parameter int         CNT_W          = 10
) (
   input logic             Clk,
   input logic             Reset_n,
   game_flow_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_START   = 3'd0,
      ST_TRANS   = 3'd1,
      ST_GAME    = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_RESULTS = 3'd4,
      ST_END     = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESULTS_FRAMES - 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_PLAYERS-1:0] win_q, win_d;
   logic                   draw_q, draw_d;
   logic [2:0]             held_q;
   logic [2:0]             down;
   logic                   press_start, press_quit, press_pause;
   logic                   any_crash;

   function automatic logic key_down(input logic [8*KEY_SLOTS-1:0] kc,
                                     input logic [7:0] key);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < KEY_SLOTS; i++) begin
         if (kc[8*i +: 8] == key) hit = 1'b1;
      end
      return hit;
   endfunction

   assign down = {key_down(bus.Keycode, START_KEY),
                  key_down(bus.Keycode, QUIT_KEY),
                  key_down(bus.Keycode, PAUSE_KEY)};

   // held_q resets high so a key already down at reset release never fires
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) held_q <= 3'b111;
      else          held_q <= down;
   end

   assign press_start = down[2] & ~held_q[2];
   assign press_quit  = down[1] & ~held_q[1];
   assign press_pause = down[0] & ~held_q[0];
   assign any_crash   = |bus.PlayerCrash;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_START;
         cnt_q   <= '0;
         win_q   <= '0;
         draw_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         draw_q  <= draw_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      win_d   = win_q;
      draw_d  = draw_q;
      unique case (state_q)
         ST_START: begin
            if (press_start) begin
               state_d = ST_TRANS;
               win_d   = '0;
               draw_d  = 1'b0;
            end
         end
         ST_TRANS: begin
            if (bus.StartTransitionDone) state_d = ST_GAME;
         end
         ST_GAME: begin
            if (press_quit) begin
               state_d = ST_END;
            end else if (any_crash) begin
               state_d = ST_RESULTS;
               win_d   = ~bus.PlayerCrash;
               draw_d  = &bus.PlayerCrash;
            end else if (press_pause) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (press_quit)       state_d = ST_END;
            else if (press_pause) state_d = ST_GAME;
         end
         ST_RESULTS: begin
            // counter is cleared on exit so it never reaches RESULTS_FRAMES
            cnt_d = cnt_q;
            if (press_quit) begin
               state_d = ST_END;
               cnt_d   = '0;
            end else if (bus.FrameTick) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_END;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_END: begin
            if (press_start) state_d = ST_START;
         end
         default: state_d = ST_START;
      endcase
   end

   assign bus.StartGame       = (state_q == ST_START) || (state_q == ST_TRANS);
   assign bus.StartTransition = (state_q == ST_TRANS);
   assign bus.DrawGame        = (state_q == ST_GAME) || (state_q == ST_PAUSE);
   assign bus.Paused          = (state_q == ST_PAUSE);
   assign bus.DrawWinner      = (state_q == ST_RESULTS);
   assign bus.EndGame         = (state_q == ST_END);
   assign bus.Winner          = win_q;
   assign bus.Draw            = draw_q;

endmodule
